psum_acc_drain: RTL and testbench

- Consumes the delay-aligned partial-sum stream from the MAC/delay-line pipeline.
- Accumulates each group of partial sums, terminated by a `last` beat, into one result.
- Scales the result by a right shift, narrows it to output width, and queues it in a 2-entry output FIFO with a valid/ready handshake toward the writeback stage.
- Sits directly downstream of the per-lane delay alignment stage.

---
 rtl/psum_acc_drain.sv | 153 +++++++++++++++
 tb/tb_psum_acc_drain.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_drain.sv
// Partial-sum group accumulator with shift/narrow and 2-entry result FIFO.
// Optional saturation on narrowing: define PSUM_ACC_SAT_EN.
module psum_acc_drain #(
  parameter  int PW    = 16,
  parameter  int AW    = 32,
  parameter  int OW    = 16,
  parameter  int SHIFT = 0,
  parameter  int MAX_K = 256,
  localparam int CW    = $clog2(MAX_K + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [PW-1:0] psum_i,
  input  logic          psum_vld,
  input  logic          psum_last,
  output logic          psum_rdy,
  output logic [OW-1:0] res_o,
  output logic [CW-1:0] res_cnt,
  output logic          res_sat,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic          ovf_err
);

  if (AW < PW + $clog2(MAX_K)) begin : g_aw_chk
    $error("psum_acc_drain: AW too narrow for PW and MAX_K");
  end
  if (OW > AW) begin : g_ow_chk
    $error("psum_acc_drain: OW must not exceed AW");
  end
  if (SHIFT < 0 || SHIFT >= AW) begin : g_sh_chk
    $error("psum_acc_drain: SHIFT out of range");
  end

  typedef enum logic {IDLE, ACC} state_t;

  typedef struct packed {
    logic [OW-1:0] res;
    logic [CW-1:0] cnt;
    logic          sat;
  } ent_t;

  state_t               state, state_n;
  logic signed [AW-1:0] acc, acc_n, psum_x, sum_n;
  logic [CW-1:0]        cnt, cnt_n, cnt_inc;
  ent_t                 fifo [2];
  ent_t                 ent_n;
  logic                 wptr, rptr;
  logic [1:0]           fcnt;
  logic                 full, accept, pop, push, ovf_set;

  // Ready is a pure function of FIFO occupancy, so res_rdy never reaches psum_rdy.
  assign full     = fcnt[1];
  assign psum_rdy = !full;
  assign res_vld  = |fcnt;
  assign accept   = psum_vld && !full && !clr;
  assign pop      = res_vld && res_rdy && !clr;

  assign psum_x  = AW'($signed(psum_i));
  assign sum_n   = ((state == ACC) ? acc : '0) + psum_x;
  assign cnt_inc = ((state == ACC) ? cnt : '0) + CW'(1);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    push    = 1'b0;
    ovf_set = 1'b0;
    if (accept) begin
      if (psum_last || cnt_inc == CW'(MAX_K)) begin
        push    = 1'b1;
        ovf_set = !psum_last;
        state_n = IDLE;
        acc_n   = '0;
        cnt_n   = '0;
      end else begin
        state_n = ACC;
        acc_n   = sum_n;
        cnt_n   = cnt_inc;
      end
    end
  end

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  logic signed [AW-1:0] f;
  assign f = sum_n >>> SHIFT;

  always_comb begin
    ent_n.cnt = cnt_inc;
    ent_n.res = f[OW-1:0];
    ent_n.sat = 1'b0;
    if (f > OMAX) begin
      ent_n.res = OMAX[OW-1:0];
      ent_n.sat = 1'b1;
    end else if (f < OMIN) begin
      ent_n.res = OMIN[OW-1:0];
      ent_n.sat = 1'b1;
    end
  end
`else
  always_comb begin
    ent_n.cnt = cnt_inc;
    ent_n.res = OW'(sum_n >>> SHIFT);
    ent_n.sat = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      fcnt    <= 2'd0;
      ovf_err <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      fcnt    <= 2'd0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      if (push) begin
        fifo[wptr] <= ent_n;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 2'd1;
        2'b01:   fcnt <= fcnt - 2'd1;
        default: fcnt <= fcnt;
      endcase
      if (ovf_set) ovf_err <= 1'b1;
    end
  end

  assign res_o   = fifo[rptr].res;
  assign res_cnt = fifo[rptr].cnt;
  assign res_sat = fifo[rptr].sat;

endmodule

// File: tb/tb_psum_acc_drain.sv
// Bench for psum_acc_drain: three parameterizations driven in lockstep and
// compared against a queue-based group/FIFO reference model.
module tb_psum_acc_drain;
  localparam int NI = 3;

  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic        psum_vld = 1'b0, psum_last = 1'b0, res_rdy = 1'b1;
  logic [15:0] psum_i = '0;

  always #5 clk = ~clk;

  logic        rdy0, vld0, sat0, ovf0;
  logic [15:0] res0;
  logic [8:0]  cnt0;
  logic        rdy1, vld1, sat1, ovf1;
  logic [15:0] res1;
  logic [2:0]  cnt1;
  logic        rdy2, vld2, sat2, ovf2;
  logic [7:0]  res2;
  logic [8:0]  cnt2;

  psum_acc_drain u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .psum_i(psum_i), .psum_vld(psum_vld),
    .psum_last(psum_last), .psum_rdy(rdy0), .res_o(res0), .res_cnt(cnt0),
    .res_sat(sat0), .res_vld(vld0), .res_rdy(res_rdy), .ovf_err(ovf0));

  psum_acc_drain #(.MAX_K(4)) u_k4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .psum_i(psum_i), .psum_vld(psum_vld),
    .psum_last(psum_last), .psum_rdy(rdy1), .res_o(res1), .res_cnt(cnt1),
    .res_sat(sat1), .res_vld(vld1), .res_rdy(res_rdy), .ovf_err(ovf1));

  psum_acc_drain #(.OW(8), .SHIFT(1)) u_n8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .psum_i(psum_i), .psum_vld(psum_vld),
    .psum_last(psum_last), .psum_rdy(rdy2), .res_o(res2), .res_cnt(cnt2),
    .res_sat(sat2), .res_vld(vld2), .res_rdy(res_rdy), .ovf_err(ovf2));

  int nvec = 0, nerr = 0;

  // reference model: open group (sum, count) and an in-order result queue
  typedef struct {longint res; int cnt; bit sat;} ent_t;
  ent_t   mq [NI][$];
  int     mk [NI] = '{256, 4, 256};
  int     mow[NI] = '{16, 16, 8};
  int     msh[NI] = '{0, 0, 1};
  bit     mopen[NI];
  longint msum[NI];
  int     mcnt[NI];
  bit     movf[NI];

  function automatic ent_t mk_ent(longint s, int c, int i);
    ent_t   e;
    longint f  = s >>> msh[i];
    longint hi = (longint'(1) << (mow[i] - 1)) - 1;
    longint lo = -hi - 1;
    e.cnt = c;
    e.sat = 1'b0;
`ifdef PSUM_ACC_SAT_EN
    if (f > hi) begin e.res = hi; e.sat = 1'b1; end
    else if (f < lo) begin e.res = lo; e.sat = 1'b1; end
    else e.res = f;
`else
    begin
      longint m = f & ((longint'(1) << mow[i]) - 1);
      if (m > hi) m = m - (longint'(1) << mow[i]);
      e.res = m;
    end
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mopen[i] = 0; msum[i] = 0; mcnt[i] = 0; movf[i] = 0;
      mq[i].delete();
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (clr) begin
        mopen[i] = 0; movf[i] = 0;
        mq[i].delete();
      end else begin
        bit do_pop = (mq[i].size() > 0) && res_rdy;
        bit do_acc = psum_vld && (mq[i].size() < 2);
        if (do_pop) void'(mq[i].pop_front());
        if (do_acc) begin
          longint s = (mopen[i] ? msum[i] : 0) + longint'($signed(psum_i));
          int     c = (mopen[i] ? mcnt[i] : 0) + 1;
          if (psum_last || c == mk[i]) begin
            mq[i].push_back(mk_ent(s, c, i));
            if (!psum_last) movf[i] = 1;
            mopen[i] = 0;
          end else begin
            mopen[i] = 1; msum[i] = s; mcnt[i] = c;
          end
        end
      end
    end
  endtask

  task automatic get_out(input int i, output bit rdy, output bit vld, output bit ovf,
                         output bit sat, output longint res, output int cnt);
    case (i)
      0: begin rdy = rdy0; vld = vld0; ovf = ovf0; sat = sat0;
               res = longint'($signed(res0)); cnt = int'(cnt0); end
      1: begin rdy = rdy1; vld = vld1; ovf = ovf1; sat = sat1;
               res = longint'($signed(res1)); cnt = int'(cnt1); end
      default: begin rdy = rdy2; vld = vld2; ovf = ovf2; sat = sat2;
               res = longint'($signed(res2)); cnt = int'(cnt2); end
    endcase
  endtask

  function automatic void chk(string nm, int i, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endfunction

  task automatic check_model();
    bit rdy, vld, ovf, sat; longint res; int cnt;
    for (int i = 0; i < NI; i++) begin
      get_out(i, rdy, vld, ovf, sat, res, cnt);
      chk("m_rdy", i, rdy, mq[i].size() < 2);
      chk("m_vld", i, vld, mq[i].size() > 0);
      chk("m_ovf", i, ovf, movf[i]);
      if (mq[i].size() > 0) begin
        chk("m_res", i, res, mq[i][0].res);
        chk("m_cnt", i, cnt, mq[i][0].cnt);
        chk("m_sat", i, sat, mq[i][0].sat);
      end
    end
  endtask

  task automatic cyc();
    check_model();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input bit l, input int p);
    psum_vld = v; psum_last = l; psum_i = 16'(p);
  endtask

  typedef struct {
    bit clr, vld, last, rdy; int psum;
    bit e_vld, e_rdy; int e_res, e_cnt;
  } vec_t;
  vec_t tv[14];

  initial begin
    bit rdy, vld, ovf, sat; longint res; int cnt;

    tv[0]  = '{0,1,0,1, 3, 0,1,0,0};
    tv[1]  = '{0,1,0,1,-1, 0,1,0,0};
    tv[2]  = '{0,1,1,1, 5, 0,1,0,0};
    tv[3]  = '{0,0,0,1, 0, 1,1,7,3};
    tv[4]  = '{0,1,1,1,-4, 0,1,0,0};
    tv[5]  = '{0,0,0,1, 0, 1,1,-4,1};
    tv[6]  = '{0,1,1,0, 1, 0,1,0,0};
    tv[7]  = '{0,1,1,0, 2, 1,1,1,1};
    tv[8]  = '{0,1,1,0, 3, 1,0,1,1};
    tv[9]  = '{0,1,1,0, 3, 1,0,1,1};
    tv[10] = '{0,1,1,1, 3, 1,0,1,1};
    tv[11] = '{0,1,1,1, 3, 1,1,2,1};
    tv[12] = '{0,0,0,1, 0, 1,1,3,1};
    tv[13] = '{0,0,0,1, 0, 0,1,0,0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    get_out(0, rdy, vld, ovf, sat, res, cnt);
    chk("rst_res", 0, res, 0);
    chk("rst_cnt", 0, cnt, 0);
    chk("rst_sat", 0, sat, 0);
    chk("rst_vld", 0, vld, 0);
    chk("rst_ovf", 0, ovf, 0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    get_out(0, rdy, vld, ovf, sat, res, cnt);
    chk("rst_rdy", 0, rdy, 1);

    // directed table on the default instance
    for (int k = 0; k < 14; k++) begin
      clr = tv[k].clr; res_rdy = tv[k].rdy;
      drive(tv[k].vld, tv[k].last, tv[k].psum);
      get_out(0, rdy, vld, ovf, sat, res, cnt);
      chk("tv_vld", k, vld, tv[k].e_vld);
      chk("tv_rdy", k, rdy, tv[k].e_rdy);
      if (tv[k].e_vld) begin
        chk("tv_res", k, res, tv[k].e_res);
        chk("tv_cnt", k, cnt, tv[k].e_cnt);
      end
      cyc();
    end

    // MAX_K=4 force-close: five non-last ones, then close the reopened group
    res_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 1);
      if (k == 4) begin
        get_out(1, rdy, vld, ovf, sat, res, cnt);
        chk("k4_vld", 1, vld, 1);
        chk("k4_res", 1, res, 4);
        chk("k4_cnt", 1, cnt, 4);
        chk("k4_ovf", 1, ovf, 1);
      end
      cyc();
    end
    drive(1, 1, 0);
    cyc();
    drive(0, 0, 0);
    get_out(1, rdy, vld, ovf, sat, res, cnt);
    chk("k4_reopen_res", 1, res, 1);
    chk("k4_reopen_cnt", 1, cnt, 2);
    cyc();

    // OW=8, SHIFT=1 narrowing of 200+100
    drive(1, 0, 200); cyc();
    drive(1, 1, 100); cyc();
    drive(0, 0, 0);
    get_out(2, rdy, vld, ovf, sat, res, cnt);
`ifdef PSUM_ACC_SAT_EN
    chk("n8_res", 2, res, 127);
    chk("n8_sat", 2, sat, 1);
`else
    chk("n8_res", 2, res, -106);
    chk("n8_sat", 2, sat, 0);
`endif
    cyc();

    // clr mid-group with one pending entry; the clr-cycle beat is dropped
    res_rdy = 1'b0;
    drive(1, 1, 7); cyc();
    drive(1, 0, 1); cyc();
    drive(1, 0, 2); cyc();
    clr = 1'b1; drive(1, 1, 50); cyc();
    clr = 1'b0; drive(1, 1, 9); res_rdy = 1'b1;
    get_out(1, rdy, vld, ovf, sat, res, cnt);
    chk("clr_vld", 1, vld, 0);
    chk("clr_ovf", 1, ovf, 0);
    cyc();
    drive(0, 0, 0);
    get_out(0, rdy, vld, ovf, sat, res, cnt);
    chk("clr_res", 0, res, 9);
    chk("clr_cnt", 0, cnt, 1);
    cyc();

    // same scenario, aborted by an asynchronous reset pulse
    res_rdy = 1'b0;
    drive(1, 1, 7); cyc();
    drive(1, 0, 1); cyc();
    drive(1, 0, 2); cyc();
    drive(0, 0, 0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    get_out(0, rdy, vld, ovf, sat, res, cnt);
    chk("arst_vld", 0, vld, 0);
    chk("arst_rdy", 0, rdy, 1);
    drive(1, 1, 9); res_rdy = 1'b1;
    cyc();
    drive(0, 0, 0);
    get_out(0, rdy, vld, ovf, sat, res, cnt);
    chk("arst_res", 0, res, 9);
    chk("arst_cnt", 0, cnt, 1);
    cyc();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      clr       = ($urandom_range(63) == 0);
      psum_vld  = ($urandom_range(3) != 0);
      psum_last = ($urandom_range(3) == 0);
      psum_i    = 16'(int'($urandom_range(2400)) - 1200);
      res_rdy   = ($urandom_range(2) != 0);
      cyc();
    end
    clr = 1'b0; drive(0, 0, 0);
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
